// File: rtl/sram_ctrl_pkg.sv
// Shared types and address-decode helpers for the banked byte-lane SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [0:0] {S_INIT, S_READY} ctrl_state_e;

  localparam int unsigned MACRO_DEPTH = 2048;

  // Row holding a given bus-word index.
  function automatic int unsigned row_of(input int unsigned word, input int unsigned depth);
    return word / depth;
  endfunction

  // Word address inside the macro of that row.
  function automatic int unsigned waddr_of(input int unsigned word, input int unsigned depth);
    return word % depth;
  endfunction

endpackage

// File: rtl/sram_byte_row.sv
// One row of byte-wide single-port SRAM lanes sharing chip select and address.
// Each lane behaves like an ST_SPHDL_2048x8m8_L macro: active-low CSN/WEN, Q registered on CK.
module sram_byte_row #(
  parameter int NUM_COLS   = 4,
  parameter int BANK_DEPTH = 2048,
  localparam int BA_BITS   = $clog2(BANK_DEPTH)
) (
  input  logic                  clk,
  input  logic                  csn,
  input  logic [NUM_COLS-1:0]   wen_vec,
  input  logic [BA_BITS-1:0]    addr,
  input  logic [NUM_COLS*8-1:0] wdata,
  output logic [NUM_COLS*8-1:0] rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COLS; gi++) begin : g_lane
      logic [7:0] mem [BANK_DEPTH];
      logic [7:0] q_reg;

      // Q only updates on a selected read; it holds across writes and idle cycles.
      always_ff @(posedge clk) begin
        if (!csn) begin
          if (!wen_vec[gi]) begin
            mem[addr] <= wdata[gi*8 +: 8];
          end else begin
            q_reg <= mem[addr];
          end
        end
      end

      assign rdata[gi*8 +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/banked_sram_ctrl.sv
// Banked byte-lane SRAM controller: req/gnt/rvalid front end, zero-fill sweep after reset,
// row decode over NUM_ROWS rows of byte macros and an optional response register stage.
module banked_sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int RAM_SIZE   = 8192,
  parameter int DATA_WIDTH = 32,
  parameter int BANK_DEPTH = MACRO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int OUT_REG    = 0,
  parameter int INIT_ZERO  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    init_done_o
);

  localparam int NUM_COLS = DATA_WIDTH / 8;
  localparam int NUM_ROWS = RAM_SIZE / (BANK_DEPTH * NUM_COLS);
  localparam int COL_BITS = $clog2(NUM_COLS);
  localparam int BA_BITS  = $clog2(BANK_DEPTH);
  localparam int ROW_BITS = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  generate
    if (RAM_SIZE != NUM_ROWS * BANK_DEPTH * NUM_COLS || DATA_WIDTH % 8 != 0) begin : g_cfg_check
      $error("banked_sram_ctrl: RAM_SIZE must equal NUM_ROWS*BANK_DEPTH*NUM_COLS, DATA_WIDTH a multiple of 8");
    end
  endgenerate

  ctrl_state_e           state_reg, state_next;
  logic [BA_BITS-1:0]    init_cnt_reg, init_cnt_next;
  logic                  init_done_reg;

  logic [31:0]           word_idx;
  logic [ROW_BITS-1:0]   req_row;
  logic [BA_BITS-1:0]    req_waddr;

  logic [NUM_ROWS-1:0]   row_csn;
  logic [NUM_COLS-1:0]   mac_wen;
  logic [BA_BITS-1:0]    mac_addr;
  logic [DATA_WIDTH-1:0] mac_wdata;
  logic [DATA_WIDTH-1:0] row_rdata [NUM_ROWS];

  logic                  rsp_valid_reg;
  logic                  rsp_read_reg;
  logic [ROW_BITS-1:0]   rd_row_reg;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [DATA_WIDTH-1:0] rdata_hold_reg;

  always_comb begin
    word_idx  = 32'(addr_i) >> COL_BITS;
    req_row   = ROW_BITS'(row_of(word_idx, BANK_DEPTH));
    req_waddr = BA_BITS'(waddr_of(word_idx, BANK_DEPTH));
  end

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    gnt_o         = 1'b0;
    row_csn       = '1;
    mac_wen       = '1;
    mac_addr      = req_waddr;
    mac_wdata     = wdata_i;
    case (state_reg)
      S_INIT: begin
        // Sweep writes zero to the same word of every lane in every row at once.
        row_csn       = '0;
        mac_wen       = '0;
        mac_addr      = init_cnt_reg;
        mac_wdata     = '0;
        init_cnt_next = init_cnt_reg + BA_BITS'(1);
        if (init_cnt_reg == BA_BITS'(BANK_DEPTH - 1)) begin
          state_next = S_READY;
        end
      end
      S_READY: begin
        gnt_o = req_i & init_done_reg;
        if (gnt_o) begin
          row_csn[req_row] = 1'b0;
          if (we_i) begin
            mac_wen = ~be_i;
          end
        end
      end
      default: state_next = S_INIT;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      sram_byte_row #(
        .NUM_COLS   (NUM_COLS),
        .BANK_DEPTH (BANK_DEPTH)
      ) u_row (
        .clk     (clk),
        .csn     (row_csn[gi]),
        .wen_vec (mac_wen),
        .addr    (mac_addr),
        .wdata   (mac_wdata),
        .rdata   (row_rdata[gi])
      );
    end
  endgenerate

  // Macro Q belongs to the grant cycle's row, so select with the row captured at grant.
  assign rd_mux = row_rdata[rd_row_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= (INIT_ZERO != 0) ? S_INIT : S_READY;
      init_cnt_reg   <= '0;
      init_done_reg  <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_read_reg   <= 1'b0;
      rd_row_reg     <= '0;
      rdata_hold_reg <= '0;
    end else begin
      state_reg     <= state_next;
      init_cnt_reg  <= init_cnt_next;
      init_done_reg <= (state_next == S_READY);
      rsp_valid_reg <= gnt_o;
      rsp_read_reg  <= gnt_o & ~we_i;
      if (gnt_o) begin
        rd_row_reg <= req_row;
      end
      if (rsp_read_reg) begin
        rdata_hold_reg <= rd_mux;
      end
    end
  end

  assign init_done_o = init_done_reg;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic rvalid_out_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          rvalid_out_reg <= 1'b0;
        end else begin
          rvalid_out_reg <= rsp_valid_reg;
        end
      end

      assign rvalid_o = rvalid_out_reg;
      assign rdata_o  = rdata_hold_reg;
    end else begin : g_out_comb
      // Write responses keep showing the last read data.
      assign rvalid_o = rsp_valid_reg;
      assign rdata_o  = rsp_read_reg ? rd_mux : rdata_hold_reg;
    end
  endgenerate

endmodule
